// File: rtl/particle_pkg.sv
// Shared constants, types and FSM encoding for the particle rasteriser.
package particle_pkg;

   localparam int FRAC_BITS = 4;
   localparam int GRID      = 16;
   localparam int CELL_W    = $clog2(GRID);

   typedef logic signed [31:0] pos_t;
   typedef logic [CELL_W-1:0]  cell_t;
   typedef logic [GRID-1:0]    row_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_PLOT,
      ST_WAIT_VSYNC,
      ST_SWAP
   } raster_state_t;

endpackage

// File: rtl/Counter.sv
// Modulo counter: counts 0..MAX while en_i is high, then wraps back to 0.
module Counter #(
   parameter int MAX   = 1023,
   parameter int WIDTH = (MAX > 0) ? $clog2(MAX + 1) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = (count_q == WIDTH'(MAX)) ? '0 : count_q + 1'b1;
      end
   end

   // NOTE: flops take '<=' so every register samples pre-edge values; '=' is kept for always_comb only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/pos_to_cell.sv
// Converts a signed fixed-point position into a grid cell index, clamped to 0..GRID-1.
module pos_to_cell
   import particle_pkg::*;
(
   input  pos_t  pos_i,
   output cell_t cell_o
);

   pos_t shifted;

   always_comb begin
      shifted = pos_i >>> FRAC_BITS;
      if (shifted < 0)                       cell_o = '0;
      else if (shifted > pos_t'(GRID - 1))   cell_o = cell_t'(GRID - 1);
      else                                   cell_o = shifted[CELL_W-1:0];
   end

endmodule

// File: rtl/particle_raster.sv
// Double-buffered 16x16 particle rasteriser with free-running row scan-out.
// Define RASTER_OVERLAP_EN to count plots that land on an already-set cell.
module particle_raster
   import particle_pkg::*;
#(
   parameter int NUM_PARTICLES = 4,
   parameter int ROW_CYCLES    = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_PARTICLES*32-1:0] pos_x,
   input  logic [NUM_PARTICLES*32-1:0] pos_y,
   output logic                        busy,
   output logic                        done,
   output logic [3:0]                  row_sel,
   output logic [15:0]                 row_data,
   output logic [7:0]                  overlap_cnt
);

   localparam int SCAN_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
   localparam int IDX_W  = (NUM_PARTICLES > 1) ? $clog2(NUM_PARTICLES) : 1;

   logic [SCAN_W-1:0] scan_cnt;
   logic              scan_wrap;
   logic              vsync;
   cell_t             row_sel_q, row_sel_d;
   row_t              row_data_q, row_data_d;

   raster_state_t     state_q, state_d;
   cell_t             clr_q, clr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              front_sel_q, front_sel_d;
   logic              back_sel;
   logic              take_start;

   pos_t              snap_x_q [NUM_PARTICLES];
   pos_t              snap_y_q [NUM_PARTICLES];
   row_t              fb_q [2][GRID];
   cell_t             cell_x, cell_y;

   Counter #(
      .MAX   (ROW_CYCLES - 1),
      .WIDTH (SCAN_W)
   ) u_scan_cnt (
      .clk     (clk),
      .reset   (reset),
      .en_i    (1'b1),
      .count_o (scan_cnt)
   );

   assign scan_wrap   = (scan_cnt == SCAN_W'(ROW_CYCLES - 1));
   assign vsync       = scan_wrap && (row_sel_q == cell_t'(GRID - 1));
   assign row_sel_d   = scan_wrap ? row_sel_q + 1'b1 : row_sel_q;
   assign take_start  = (state_q == ST_IDLE) && start;
   assign back_sel    = ~front_sel_q;
   assign front_sel_d = front_sel_q ^ (state_q == ST_SWAP);
   // Read through the post-edge front select so the first sample after a swap is already the new frame.
   assign row_data_d  = fb_q[front_sel_d][row_sel_q];

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      idx_d   = idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CLEAR;
               clr_d   = '0;
            end
         end
         ST_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == cell_t'(GRID - 1)) begin
               state_d = ST_PLOT;
               idx_d   = '0;
            end
         end
         ST_PLOT: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_PARTICLES - 1)) state_d = ST_WAIT_VSYNC;
         end
         ST_WAIT_VSYNC: begin
            if (vsync) state_d = ST_SWAP;
         end
         ST_SWAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         clr_q       <= '0;
         idx_q       <= '0;
         front_sel_q <= 1'b0;
         row_sel_q   <= '0;
         row_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         clr_q       <= clr_d;
         idx_q       <= idx_d;
         front_sel_q <= front_sel_d;
         row_sel_q   <= row_sel_d;
         row_data_q  <= row_data_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_PARTICLES; i++) begin
            snap_x_q[i] <= '0;
            snap_y_q[i] <= '0;
         end
      end else if (take_start) begin
         for (int i = 0; i < NUM_PARTICLES; i++) begin
            snap_x_q[i] <= pos_x[32*i +: 32];
            snap_y_q[i] <= pos_y[32*i +: 32];
         end
      end
   end

   pos_to_cell u_cell_x (.pos_i(snap_x_q[idx_q]), .cell_o(cell_x));
   pos_to_cell u_cell_y (.pos_i(snap_y_q[idx_q]), .cell_o(cell_y));

   // NOTE: the framebuffers live in flops rather than RAM so they can be reset; the display must come up blank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < GRID; r++) fb_q[b][r] <= '0;
         end
      end else if (state_q == ST_CLEAR) begin
         fb_q[back_sel][clr_q] <= '0;
      end else if (state_q == ST_PLOT) begin
         fb_q[back_sel][cell_y][cell_x] <= 1'b1;
      end
   end

`ifdef RASTER_OVERLAP_EN
   logic [7:0] ovl_q, ovl_d, ovl_out_q;
   logic       hit;

   assign hit = fb_q[back_sel][cell_y][cell_x];

   always_comb begin
      ovl_d = ovl_q;
      if (take_start) ovl_d = '0;
      else if ((state_q == ST_PLOT) && hit && (ovl_q != 8'hFF)) ovl_d = ovl_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovl_q     <= '0;
         ovl_out_q <= '0;
      end else begin
         ovl_q <= ovl_d;
         if (state_q == ST_SWAP) ovl_out_q <= ovl_q;
      end
   end

   assign overlap_cnt = ovl_out_q;
`else
   assign overlap_cnt = 8'd0;
`endif

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_SWAP);
   assign row_sel  = row_sel_q;
   assign row_data = row_data_q;

endmodule
